// File: rtl/sram_access_unit.sv
// CPU-side master for the SRAM controller: serialises a fetch and/or a load/store onto
// the controller's slot A and slot EX, builds lane masks and store data, extends load data.
module sram_access_unit #(
    parameter int unsigned BUS_AW = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic              mem_sign,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              if_addr_err,
    output logic [31:0]       mem_rdata,
    output logic              mem_valid,
    output logic              mem_addr_err,
    output logic              cpu_stall,
    output logic              read_op,
    output logic              write_op,
    output logic [BUS_AW-1:0] bus_addr,
    output logic [3:0]        byte_mask,
    output logic [31:0]       bus_data_write,
    output logic              read_op_ex,
    output logic              write_op_ex,
    output logic [BUS_AW-1:0] bus_addr_ex,
    output logic [3:0]        byte_mask_ex,
    output logic [31:0]       bus_data_write_ex,
    input  logic [31:0]       bus_data_read,
    input  logic [31:0]       bus_data_read_ex
);

    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_A = 3'd1,
        ISSUE_B = 3'd2,
        CAP_A   = 3'd3,
        CAP_B   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t state_q, state_d;

    // Request context latched in IDLE
    logic       a_fetch_q, a_fetch_d;
    logic       dual_q, dual_d;
    logic       has_if_q, has_if_d;
    logic       has_mem_q, has_mem_d;
    logic       if_err_q, if_err_d;
    logic       mem_err_q, mem_err_d;
    logic       we_q, we_d;
    logic [1:0] size_q, size_d;
    logic       sign_q, sign_d;
    logic [1:0] off_q, off_d;

    logic              read_op_d, write_op_d, read_op_ex_d, write_op_ex_d;
    logic              if_valid_d, mem_valid_d, if_addr_err_d, mem_addr_err_d;
    logic [DW-1:0]     if_rdata_d, mem_rdata_d;
    logic [BUS_AW-1:0] bus_addr_d, bus_addr_ex_d;
    logic [MW-1:0]     byte_mask_d, byte_mask_ex_d;
    logic [DW-1:0]     bus_data_write_d, bus_data_write_ex_d;

    logic              if_mis, mem_mis, good_if, good_mem;
    logic [MW-1:0]     mem_mask;
    logic [DW-1:0]     mem_data;
    logic [BUS_AW-1:0] if_baddr, mem_baddr;
    logic              unused_bits;

    assign if_mis    = (if_addr[1:0] != 2'b00);
    assign mem_mis   = mem_size[1] ? (mem_addr[1:0] != 2'b00) : (mem_size[0] & mem_addr[0]);
    assign good_if   = if_req & ~if_mis;
    assign good_mem  = mem_req & ~mem_mis;
    assign if_baddr  = {if_addr[BUS_AW-1:2], 2'b00};
    assign mem_baddr = {mem_addr[BUS_AW-1:2], 2'b00};
    assign unused_bits = ^{if_addr[DW-1:BUS_AW], mem_addr[DW-1:BUS_AW]};

    // Lane enables and replicated store data for the data access
    always_comb begin
        mem_mask = 4'b1111;
        mem_data = mem_wdata;
        case (mem_size)
            2'd0: begin
                mem_mask = 4'b0001 << mem_addr[1:0];
                mem_data = {4{mem_wdata[7:0]}};
            end
            2'd1: begin
                mem_mask = 4'b0011 << {mem_addr[1], 1'b0};
                mem_data = {2{mem_wdata[15:0]}};
            end
            default: begin
                mem_mask = 4'b1111;
                mem_data = mem_wdata;
            end
        endcase
    end

    function automatic logic [DW-1:0] load_extract(input logic [DW-1:0] rd,
                                                   input logic [1:0]    off,
                                                   input logic [1:0]    size,
                                                   input logic          sign);
        logic [DW-1:0] w;
        w = rd >> {off, 3'b000};
        case (size)
            2'd0:    return {{24{sign & w[7]}}, w[7:0]};
            2'd1:    return {{16{sign & w[15]}}, w[15:0]};
            default: return rd;
        endcase
    endfunction

    // Stall is combinational so the pipeline holds in the very cycle a request appears
    assign cpu_stall = (state_q == DONE) ? 1'b0 :
                       (state_q == IDLE) ? (if_req | mem_req) : 1'b1;

    always_comb begin
        state_d             = state_q;
        a_fetch_d           = a_fetch_q;
        dual_d              = dual_q;
        has_if_d            = has_if_q;
        has_mem_d           = has_mem_q;
        if_err_d            = if_err_q;
        mem_err_d           = mem_err_q;
        we_d                = we_q;
        size_d              = size_q;
        sign_d              = sign_q;
        off_d               = off_q;
        read_op_d           = 1'b0;
        write_op_d          = 1'b0;
        read_op_ex_d        = 1'b0;
        write_op_ex_d       = 1'b0;
        if_valid_d          = 1'b0;
        mem_valid_d         = 1'b0;
        if_addr_err_d       = 1'b0;
        mem_addr_err_d      = 1'b0;
        if_rdata_d          = if_rdata;
        mem_rdata_d         = mem_rdata;
        bus_addr_d          = bus_addr;
        bus_addr_ex_d       = bus_addr_ex;
        byte_mask_d         = byte_mask;
        byte_mask_ex_d      = byte_mask_ex;
        bus_data_write_d    = bus_data_write;
        bus_data_write_ex_d = bus_data_write_ex;

        case (state_q)
            IDLE: begin
                if (if_req | mem_req) begin
                    a_fetch_d = good_if;
                    dual_d    = good_if & good_mem;
                    has_if_d  = if_req;
                    has_mem_d = mem_req;
                    if_err_d  = if_req & if_mis;
                    mem_err_d = mem_req & mem_mis;
                    we_d      = mem_we;
                    size_d    = mem_size;
                    sign_d    = mem_sign;
                    off_d     = mem_addr[1:0];
                    if (good_if) begin
                        bus_addr_d       = if_baddr;
                        byte_mask_d      = 4'b1111;
                        bus_data_write_d = '0;
                        if (good_mem) begin
                            bus_addr_ex_d       = mem_baddr;
                            byte_mask_ex_d      = mem_mask;
                            bus_data_write_ex_d = mem_data;
                        end
                    end else if (good_mem) begin
                        bus_addr_d       = mem_baddr;
                        byte_mask_d      = mem_mask;
                        bus_data_write_d = mem_data;
                    end
                    if (good_if | good_mem) begin
                        state_d    = ISSUE_A;
                        read_op_d  = good_if | ~mem_we;
                        write_op_d = ~good_if & mem_we;
                    end else begin
                        // Errors only: report straight away without touching the bus
                        state_d        = DONE;
                        if_valid_d     = if_req;
                        mem_valid_d    = mem_req;
                        if_addr_err_d  = if_req & if_mis;
                        mem_addr_err_d = mem_req & mem_mis;
                    end
                end
            end
            ISSUE_A: begin
                state_d       = ISSUE_B;
                read_op_ex_d  = dual_q & ~we_q;
                write_op_ex_d = dual_q & we_q;
            end
            ISSUE_B: begin
                state_d = CAP_A;
            end
            CAP_A: begin
                if (a_fetch_q) begin
                    if_rdata_d = bus_data_read;
                end else if (!we_q) begin
                    mem_rdata_d = load_extract(bus_data_read, off_q, size_q, sign_q);
                end
                if (dual_q) begin
                    state_d = CAP_B;
                end else begin
                    state_d        = DONE;
                    if_valid_d     = has_if_q;
                    mem_valid_d    = has_mem_q;
                    if_addr_err_d  = if_err_q;
                    mem_addr_err_d = mem_err_q;
                end
            end
            CAP_B: begin
                if (!we_q) begin
                    mem_rdata_d = load_extract(bus_data_read_ex, off_q, size_q, sign_q);
                end
                state_d        = DONE;
                if_valid_d     = has_if_q;
                mem_valid_d    = has_mem_q;
                if_addr_err_d  = if_err_q;
                mem_addr_err_d = mem_err_q;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            a_fetch_q         <= 1'b0;
            dual_q            <= 1'b0;
            has_if_q          <= 1'b0;
            has_mem_q         <= 1'b0;
            if_err_q          <= 1'b0;
            mem_err_q         <= 1'b0;
            we_q              <= 1'b0;
            size_q            <= 2'd0;
            sign_q            <= 1'b0;
            off_q             <= 2'd0;
            read_op           <= 1'b0;
            write_op          <= 1'b0;
            read_op_ex        <= 1'b0;
            write_op_ex       <= 1'b0;
            if_valid          <= 1'b0;
            mem_valid         <= 1'b0;
            if_addr_err       <= 1'b0;
            mem_addr_err      <= 1'b0;
            if_rdata          <= '0;
            mem_rdata         <= '0;
            bus_addr          <= '0;
            bus_addr_ex       <= '0;
            byte_mask         <= '0;
            byte_mask_ex      <= '0;
            bus_data_write    <= '0;
            bus_data_write_ex <= '0;
        end else begin
            state_q           <= state_d;
            a_fetch_q         <= a_fetch_d;
            dual_q            <= dual_d;
            has_if_q          <= has_if_d;
            has_mem_q         <= has_mem_d;
            if_err_q          <= if_err_d;
            mem_err_q         <= mem_err_d;
            we_q              <= we_d;
            size_q            <= size_d;
            sign_q            <= sign_d;
            off_q             <= off_d;
            read_op           <= read_op_d;
            write_op          <= write_op_d;
            read_op_ex        <= read_op_ex_d;
            write_op_ex       <= write_op_ex_d;
            if_valid          <= if_valid_d;
            mem_valid         <= mem_valid_d;
            if_addr_err       <= if_addr_err_d;
            mem_addr_err      <= mem_addr_err_d;
            if_rdata          <= if_rdata_d;
            mem_rdata         <= mem_rdata_d;
            bus_addr          <= bus_addr_d;
            bus_addr_ex       <= bus_addr_ex_d;
            byte_mask         <= byte_mask_d;
            byte_mask_ex      <= byte_mask_ex_d;
            bus_data_write    <= bus_data_write_d;
            bus_data_write_ex <= bus_data_write_ex_d;
        end
    end

endmodule

// File: tb/tb_sram_access_unit.sv
// Directed bench for sram_access_unit with a two-cycle-latency SRAM read model.
module tb_sram_access_unit;

    localparam int unsigned BUS_AW = 22;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [31:0]       if_addr = '0;
    logic              mem_req = 1'b0;
    logic              mem_we = 1'b0;
    logic [1:0]        mem_size = '0;
    logic              mem_sign = 1'b0;
    logic [31:0]       mem_addr = '0;
    logic [31:0]       mem_wdata = '0;
    logic [31:0]       if_rdata, mem_rdata;
    logic              if_valid, if_addr_err, mem_valid, mem_addr_err, cpu_stall;
    logic              read_op, write_op, read_op_ex, write_op_ex;
    logic [BUS_AW-1:0] bus_addr, bus_addr_ex;
    logic [3:0]        byte_mask, byte_mask_ex;
    logic [31:0]       bus_data_write, bus_data_write_ex;
    logic [31:0]       bus_data_read, bus_data_read_ex;

    sram_access_unit #(.BUS_AW(BUS_AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_sign(mem_sign),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_addr_err(if_addr_err),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_addr_err(mem_addr_err),
        .cpu_stall(cpu_stall),
        .read_op(read_op), .write_op(write_op),
        .bus_addr(bus_addr), .byte_mask(byte_mask), .bus_data_write(bus_data_write),
        .read_op_ex(read_op_ex), .write_op_ex(write_op_ex),
        .bus_addr_ex(bus_addr_ex), .byte_mask_ex(byte_mask_ex),
        .bus_data_write_ex(bus_data_write_ex),
        .bus_data_read(bus_data_read), .bus_data_read_ex(bus_data_read_ex)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_word(input logic [31:0] a);
        case (a)
            32'h0000_1004: return 32'h2402_0005;
            32'h0000_0200: return 32'h80FF_1234;
            32'h0000_0400: return 32'h1122_3344;
            32'h0000_0100: return 32'hCAFE_F00D;
            32'h0000_0300: return 32'h8765_A5C3;
            default:       return 32'h0000_0000;
        endcase
    endfunction

    // Read data appears exactly two cycles after the issuing pulse, junk otherwise
    logic              a1_v = 1'b0, a2_v = 1'b0, e1_v = 1'b0, e2_v = 1'b0;
    logic [BUS_AW-1:0] a1_a = '0, a2_a = '0, e1_a = '0, e2_a = '0;
    always @(posedge clk) begin
        a1_v <= read_op;    a1_a <= bus_addr;    a2_v <= a1_v; a2_a <= a1_a;
        e1_v <= read_op_ex; e1_a <= bus_addr_ex; e2_v <= e1_v; e2_a <= e1_a;
    end
    assign bus_data_read    = a2_v ? model_word(32'(a2_a)) : 32'hDEAD_BEEF;
    assign bus_data_read_ex = e2_v ? model_word(32'(e2_a)) : 32'hDEAD_BEEF;

    typedef struct {
        logic ifr; logic [31:0] ia;
        logic mr; logic we; logic [1:0] sz; logic sg; logic [31:0] ma; logic [31:0] wd;
        logic a_op; logic a_we; logic [31:0] a_addr; logic [3:0] a_mask; logic [31:0] a_data;
        logic ex_op; logic ex_we; logic [31:0] ex_addr; logic [3:0] ex_mask; logic [31:0] ex_data;
        int done; logic ifv; logic iferr; logic memv; logic memerr;
        logic [31:0] if_rd; logic [31:0] mem_rd;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];
    vec_t post_rst;
    int   tests = 0;
    int   fails = 0;
    int   cur = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL v%0d %s: got %h expected %h", cur, name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int a_cnt = 0, ex_cnt = 0, ifv_cnt = 0, memv_cnt = 0;
        int a_cyc = -1, ex_cyc = -1, done_c = -1;
        logic a_we_s = 0, ex_we_s = 0, stall_ok = 1, iferr_s = 0, memerr_s = 0;
        logic [31:0] a_addr_s = 0, a_data_s = 0, ex_addr_s = 0, ex_data_s = 0;
        logic [31:0] if_rd_s = 0, mem_rd_s = 0;
        logic [3:0] a_mask_s = 0, ex_mask_s = 0;
        @(posedge clk); #1;
        if_req = v.ifr; if_addr = v.ia;
        mem_req = v.mr; mem_we = v.we; mem_size = v.sz; mem_sign = v.sg;
        mem_addr = v.ma; mem_wdata = v.wd;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            if (read_op | write_op) begin
                a_cnt++; a_cyc = c; a_we_s = write_op; a_addr_s = 32'(bus_addr);
                a_mask_s = byte_mask; a_data_s = bus_data_write;
            end
            if (read_op_ex | write_op_ex) begin
                ex_cnt++; ex_cyc = c; ex_we_s = write_op_ex; ex_addr_s = 32'(bus_addr_ex);
                ex_mask_s = byte_mask_ex; ex_data_s = bus_data_write_ex;
            end
            if (if_valid) ifv_cnt++;
            if (mem_valid) memv_cnt++;
            if (if_valid | mem_valid) begin
                done_c = c; iferr_s = if_addr_err; memerr_s = mem_addr_err;
                if_rd_s = if_rdata; mem_rd_s = mem_rdata;
            end
            if (cpu_stall !== (done_c != c)) stall_ok = 0;
            if (done_c >= 0) break;
        end
        @(posedge clk); #1;
        if_req = 0; mem_req = 0;
        @(negedge clk);
        chk("post_idle", {28'(0), cpu_stall, if_valid, mem_valid, read_op | write_op}, 32'h0);
        chk("done_cycle", 32'(done_c), 32'(v.done));
        chk("stall", 32'(stall_ok), 32'h1);
        chk("a_count", 32'(a_cnt), 32'(v.a_op));
        if (v.a_op) begin
            chk("a_cycle", 32'(a_cyc), 32'd1);
            chk("a_we", 32'(a_we_s), 32'(v.a_we));
            chk("a_addr", a_addr_s, v.a_addr);
            chk("a_mask", 32'(a_mask_s), 32'(v.a_mask));
            if (v.a_we) chk("a_data", a_data_s, v.a_data);
        end
        chk("ex_count", 32'(ex_cnt), 32'(v.ex_op));
        if (v.ex_op) begin
            chk("ex_cycle", 32'(ex_cyc), 32'd2);
            chk("ex_we", 32'(ex_we_s), 32'(v.ex_we));
            chk("ex_addr", ex_addr_s, v.ex_addr);
            chk("ex_mask", 32'(ex_mask_s), 32'(v.ex_mask));
            if (v.ex_we) chk("ex_data", ex_data_s, v.ex_data);
        end
        chk("if_valid_cnt", 32'(ifv_cnt), 32'(v.ifv));
        chk("mem_valid_cnt", 32'(memv_cnt), 32'(v.memv));
        if (v.ifv) chk("if_addr_err", 32'(iferr_s), 32'(v.iferr));
        if (v.memv) chk("mem_addr_err", 32'(memerr_s), 32'(v.memerr));
        chk("if_rdata", if_rd_s, v.if_rd);
        chk("mem_rdata", mem_rd_s, v.mem_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ifr ia | mr we sz sg ma wd | a_op a_we a_addr a_mask a_data | ex ... | done ifv iferr memv memerr | if_rd mem_rd
        vecs[0]  = '{1, 32'h1004, 0,0,2'd2,0, 32'h0,   32'h0,        1,0,32'h1004,4'hF,32'h0,        0,0,32'h0,4'h0,32'h0,           4, 1,0,0,0, 32'h24020005, 32'h00000000};
        vecs[1]  = '{0, 32'h0,    1,0,2'd0,1, 32'h203, 32'h0,        1,0,32'h200, 4'h8,32'h0,        0,0,32'h0,4'h0,32'h0,           4, 0,0,1,0, 32'h24020005, 32'hFFFFFF80};
        vecs[2]  = '{0, 32'h0,    1,0,2'd0,0, 32'h203, 32'h0,        1,0,32'h200, 4'h8,32'h0,        0,0,32'h0,4'h0,32'h0,           4, 0,0,1,0, 32'h24020005, 32'h00000080};
        vecs[3]  = '{0, 32'h0,    1,1,2'd1,0, 32'h202, 32'h0000ABCD, 1,1,32'h200, 4'hC,32'hABCDABCD, 0,0,32'h0,4'h0,32'h0,           4, 0,0,1,0, 32'h24020005, 32'h00000080};
        vecs[4]  = '{1, 32'h100,  1,0,2'd2,0, 32'h400, 32'h0,        1,0,32'h100, 4'hF,32'h0,        1,0,32'h400,4'hF,32'h0,         5, 1,0,1,0, 32'hCAFEF00D, 32'h11223344};
        vecs[5]  = '{0, 32'h0,    1,0,2'd2,0, 32'h401, 32'h0,        0,0,32'h0,   4'h0,32'h0,        0,0,32'h0,4'h0,32'h0,           1, 0,0,1,1, 32'hCAFEF00D, 32'h11223344};
        vecs[6]  = '{0, 32'h0,    1,0,2'd1,1, 32'h302, 32'h0,        1,0,32'h300, 4'hC,32'h0,        0,0,32'h0,4'h0,32'h0,           4, 0,0,1,0, 32'hCAFEF00D, 32'hFFFF8765};
        vecs[7]  = '{0, 32'h0,    1,0,2'd1,1, 32'h300, 32'h0,        1,0,32'h300, 4'h3,32'h0,        0,0,32'h0,4'h0,32'h0,           4, 0,0,1,0, 32'hCAFEF00D, 32'hFFFFA5C3};
        vecs[8]  = '{0, 32'h0,    1,0,2'd0,1, 32'h301, 32'h0,        1,0,32'h300, 4'h2,32'h0,        0,0,32'h0,4'h0,32'h0,           4, 0,0,1,0, 32'hCAFEF00D, 32'hFFFFFFA5};
        vecs[9]  = '{0, 32'h0,    1,1,2'd0,0, 32'h105, 32'h123456EF, 1,1,32'h104, 4'h2,32'hEFEFEFEF, 0,0,32'h0,4'h0,32'h0,           4, 0,0,1,0, 32'hCAFEF00D, 32'hFFFFFFA5};
        vecs[10] = '{0, 32'h0,    1,1,2'd2,0, 32'h208, 32'hDEADBEEF, 1,1,32'h208, 4'hF,32'hDEADBEEF, 0,0,32'h0,4'h0,32'h0,           4, 0,0,1,0, 32'hCAFEF00D, 32'hFFFFFFA5};
        vecs[11] = '{1, 32'h1004, 1,1,2'd0,0, 32'h203, 32'h00000055, 1,0,32'h1004,4'hF,32'h0,        1,1,32'h200,4'h8,32'h55555555,  5, 1,0,1,0, 32'h24020005, 32'hFFFFFFA5};
        vecs[12] = '{1, 32'h1006, 1,0,2'd2,0, 32'h200, 32'h0,        1,0,32'h200, 4'hF,32'h0,        0,0,32'h0,4'h0,32'h0,           4, 1,1,1,0, 32'h24020005, 32'h80FF1234};
        vecs[13] = '{1, 32'h1002, 0,0,2'd2,0, 32'h0,   32'h0,        0,0,32'h0,   4'h0,32'h0,        0,0,32'h0,4'h0,32'h0,           1, 1,1,0,0, 32'h24020005, 32'h80FF1234};
        vecs[14] = '{1, 32'h100,  1,0,2'd1,0, 32'h201, 32'h0,        1,0,32'h100, 4'hF,32'h0,        0,0,32'h0,4'h0,32'h0,           4, 1,0,1,1, 32'hCAFEF00D, 32'h80FF1234};
        vecs[15] = '{0, 32'h0,    1,0,2'd3,1, 32'h400, 32'h0,        1,0,32'h400, 4'hF,32'h0,        0,0,32'h0,4'h0,32'h0,           4, 0,0,1,0, 32'hCAFEF00D, 32'h11223344};
        vecs[16] = '{0, 32'h0,    1,0,2'd3,0, 32'h402, 32'h0,        0,0,32'h0,   4'h0,32'h0,        0,0,32'h0,4'h0,32'h0,           1, 0,0,1,1, 32'hCAFEF00D, 32'h11223344};
        post_rst = '{1, 32'h1004, 0,0,2'd2,0, 32'h0,   32'h0,        1,0,32'h1004,4'hF,32'h0,        0,0,32'h0,4'h0,32'h0,           4, 1,0,0,0, 32'h24020005, 32'h00000000};

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_pulses", {24'(0), cpu_stall, if_valid, mem_valid, if_addr_err, mem_addr_err,
                           read_op | write_op, read_op_ex, write_op_ex}, 32'h0);
        chk("rst_rdata", if_rdata | mem_rdata, 32'h0);
        chk("rst_bus", {bus_addr[BUS_AW-1:2], byte_mask, byte_mask_ex} | 32'(bus_addr_ex), 32'h0);

        for (int i = 0; i < NV; i++) begin
            cur = i;
            run_vec(vecs[i]);
        end

        // Reset in C2 of a dual access abandons it
        cur = 100;
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h100; mem_req = 1; mem_we = 0; mem_size = 2'd2; mem_addr = 32'h400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1; if_req = 0; mem_req = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_mid_ops", {26'(0), read_op, write_op, read_op_ex, write_op_ex, if_valid, mem_valid}, 32'h0);
        chk("rst_mid_stall", 32'(cpu_stall), 32'h0);
        chk("rst_mid_rdata", if_rdata | mem_rdata, 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_quiet", {29'(0), read_op_ex | write_op_ex, if_valid, mem_valid}, 32'h0);
        end
        cur = 101;
        run_vec(post_rst);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
